// File: rtl/inv_permute_pkg.sv
// Shared types and helpers for the inverse lane-permutation block.
// The controller state encoding, the lane count and the source-index function live here.
package inv_permute_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_LANES = 25;
  localparam logic [4:0] LAST_LANE = 5'(NUM_LANES - 1);

  // Output lane x+5y comes from buffered lane y+5*((2x+3y) mod 5).
  function automatic logic [4:0] src_idx(input logic [4:0] idx);
    int x;
    int y;
    x = int'(idx) % 5;
    y = int'(idx) / 5;
    return 5'(y + 5 * ((2 * x + 3 * y) % 5));
  endfunction

endpackage

// File: rtl/inv_permute_if.sv
// Handshake and lane bus of inv_permute.
// The slave modport is the block itself; the master modport is the driving side.
interface inv_permute_if #(
  parameter int LANE_W = 64
);
  logic              start;
  logic              ready;
  logic              in_valid;
  logic [LANE_W-1:0] in_lane;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_lane;
  logic              done;
  logic              err;

  modport slave (
    input  start, in_valid, in_lane, out_ready,
    output ready, out_valid, out_lane, done, err
  );

  modport master (
    output start, in_valid, in_lane, out_ready,
    input  ready, out_valid, out_lane, done, err
  );
endinterface

// File: rtl/inv_permute_cu.sv
// Controller of inv_permute: Idle/Read/Write/Done FSM, counter and buffer strobes, error flag.
// Optional protocol error flag enabled by defining INV_PERMUTE_ERR_EN.
module inv_permute_cu
  import inv_permute_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic in_valid_i,
  input  logic out_ready_i,
  input  logic cnt_last_i,
  output logic ready_o,
  output logic out_valid_o,
  output logic done_o,
  output logic err_o,
  output logic cnt_clr_o,
  output logic cnt_inc_o,
  output logic buf_we_o
);

  state_e state_q;
  state_e state_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter/buffer strobes
  always_comb begin
    state_d   = state_q;
    cnt_clr_o = 1'b0;
    cnt_inc_o = 1'b0;
    buf_we_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_READ;
          cnt_clr_o = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (in_valid_i) begin
          buf_we_o = 1'b1;
          if (cnt_last_i) begin
            state_d   = ST_WRITE;
            cnt_clr_o = 1'b1;
          end else begin
            cnt_inc_o = 1'b1;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (out_ready_i) begin
          if (cnt_last_i) begin
            state_d = ST_DONE;
          end else begin
            cnt_inc_o = 1'b1;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_WRITE);
  assign done_o      = (state_q == ST_DONE);

`ifdef INV_PERMUTE_ERR_EN
  logic err_q;
  logic err_d;

  // Sticky flag: start while busy, or a lane offered outside Read
  always_comb begin
    err_d = err_q;
    if ((start_i && ((state_q == ST_READ) || (state_q == ST_WRITE))) ||
        (in_valid_i && (state_q != ST_READ))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/inv_permute.sv
// Inverse lane permutation: buffers 25 permuted lanes, then emits them in original order.
// Define INV_PERMUTE_ERR_EN to enable the sticky protocol error flag.
module inv_permute
  import inv_permute_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  inv_permute_if.slave  bus
);

  logic [4:0]        cnt_q;
  logic [4:0]        cnt_d;
  logic              cnt_clr_s;
  logic              cnt_inc_s;
  logic              buf_we_s;
  logic [LANE_W-1:0] lane_buf_q [NUM_LANES];

  inv_permute_cu u_cu (
    .clk         (clk),
    .rst         (rst),
    .start_i     (bus.start),
    .in_valid_i  (bus.in_valid),
    .out_ready_i (bus.out_ready),
    .cnt_last_i  (cnt_q == LAST_LANE),
    .ready_o     (bus.ready),
    .out_valid_o (bus.out_valid),
    .done_o      (bus.done),
    .err_o       (bus.err),
    .cnt_clr_o   (cnt_clr_s),
    .cnt_inc_o   (cnt_inc_s),
    .buf_we_o    (buf_we_s)
  );

  // Lane counter, saturating at the last lane
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_s) begin
      cnt_d = 5'd0;
    end else if (cnt_inc_s && (cnt_q != LAST_LANE)) begin
      cnt_d = cnt_q + 5'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Lane buffer; contents are meaningless until a Read completes, so no reset
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      lane_buf_q[cnt_q] <= bus.in_lane;
    end
  end

  assign bus.out_lane = lane_buf_q[src_idx(cnt_q)];

endmodule

// File: tb/tb_inv_permute.sv
// Scoreboard bench for inv_permute: a forward-permute model supplies expected lanes,
// a negedge monitor pops and compares every accepted output lane.
module tb_inv_permute;

  localparam int LW = 64;
`ifdef INV_PERMUTE_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] orig_a [25];
  logic [LW-1:0] perm_a [25];

  inv_permute_if #(.LANE_W(LW)) ifc ();

  inv_permute #(.LANE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted output lane is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_lane", ifc.out_lane, '0);
          errors += (ifc.out_lane === '0) ? 1 : 0;
        end else begin
          chk($sformatf("lane_%0d", acc_cnt), ifc.out_lane, exp_q.pop_front());
        end
        acc_cnt++;
      end
      if (ifc.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // The encoder moves lane (x,y) to (y,(2x+3y) mod 5); derive perm from orig
  task automatic fwd_from_orig();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        perm_a[y + 5 * ((2 * x + 3 * y) % 5)] = orig_a[x + 5 * y];
  endtask

  task automatic orig_from_perm();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        orig_a[x + 5 * y] = perm_a[y + 5 * ((2 * x + 3 * y) % 5)];
  endtask

  task automatic run_block(input bit gap, input bit stall, input bit abort, input bit err_poke);
    int n;
    int c0;
    int done_base;
    bit aborted;
    bit stalled;
    n = 0;
    while (!ifc.ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_start", {63'd0, ifc.ready}, 64'd1);
    acc_cnt   = 0;
    done_base = done_cnt;
    aborted   = 1'b0;
    stalled   = 1'b0;
    for (int i = 0; i < 25; i++) exp_q.push_back(orig_a[i]);
    c0 = cyc;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (gap) begin
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      ifc.in_valid = 1'b1;
      ifc.in_lane  = perm_a[i];
      ifc.start    = (err_poke && i == 5);
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.start    = 1'b0;
    n = 0;
    while (done_cnt == done_base && n < 400 && !aborted) begin
      if (stall && !stalled && acc_cnt == 7) begin
        stalled = 1'b1;
        ifc.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold_lane", ifc.out_lane, orig_a[7]);
          chk("stall_valid", {63'd0, ifc.out_valid}, 64'd1);
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        n += 3;
      end else if (abort && acc_cnt == 10) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (aborted) begin
      chk("ready_after_abort", {63'd0, ifc.ready}, 64'd1);
      chk("valid_after_abort", {63'd0, ifc.out_valid}, 64'd0);
      repeat (60) @(posedge clk);
      #1;
      chk("no_done_on_abort", 64'(done_cnt - done_base), 64'd0);
    end else begin
      chk("ready_after_done", {63'd0, ifc.ready}, 64'd1);
      if (!gap && !stall) chk("done_latency", 64'(done_cyc - c0), 64'd51);
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", 64'(done_cnt - done_base), 64'd1);
      chk("lanes_out", 64'(acc_cnt), 64'd25);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("err_flag", {63'd0, ifc.err}, err_poke ? {63'd0, EXP_ERR} : 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifc.start     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_lane   = '0;
    ifc.out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", {63'd0, ifc.ready}, 64'd1);
      chk("idle_valid", {63'd0, ifc.out_valid}, 64'd0);
      chk("idle_done", {63'd0, ifc.done}, 64'd0);
      chk("idle_err", {63'd0, ifc.err}, 64'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) perm_a[i] = 64'(i);
    orig_from_perm();
    run_block(1'b0, 1'b0, 1'b0, 1'b0);
    run_block(1'b1, 1'b1, 1'b0, 1'b0);

    repeat (3) begin
      for (int i = 0; i < 25; i++) orig_a[i] = {$urandom, $urandom};
      fwd_from_orig();
      run_block(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 25; i++) orig_a[i] = {$urandom, $urandom};
    fwd_from_orig();
    run_block(1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 25; i++) orig_a[i] = {$urandom, $urandom};
    fwd_from_orig();
    run_block(1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) orig_a[i] = {$urandom, $urandom};
    fwd_from_orig();
    run_block(1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
